ifu: RTL and testbench

IFU -- requirements
Module: ifu

---
 rtl/ifu.sv | 152 +++++++++++++++
 tb/tb_ifu.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu.sv
// Instruction fetch unit: IDLE/FETCH/VALID handshake between instruction memory and decode.
// Optional fetch timeout with sticky error state is enabled by defining IFU_TIMEOUT_EN.
`ifndef IFU_DATAWIDTH
`define IFU_DATAWIDTH 32
`endif

module ifu #(
    parameter logic [`IFU_DATAWIDTH-1:0] RESET_PC    = 32'h0000_0000,
    parameter int                        TIMEOUT_CYC = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      imem_req,
    output logic [`IFU_DATAWIDTH-1:0] imem_addr,
    input  logic                      imem_ack,
    input  logic [`IFU_DATAWIDTH-1:0] imem_rdata,
    output logic [`IFU_DATAWIDTH-1:0] instr,
    output logic                      instr_valid,
    input  logic                      instr_ready,
    output logic [`IFU_DATAWIDTH-1:0] PC_now,
    output logic [`IFU_DATAWIDTH-1:0] PC_plus4,
    input  logic                      redirect,
    input  logic [`IFU_DATAWIDTH-1:0] redirect_target,
    output logic                      fetch_err
);

    localparam int W = `IFU_DATAWIDTH;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        VALID
`ifdef IFU_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   pc_q, pc_d;
    logic [W-1:0]   instr_q, instr_d;
    logic [W-1:0]   tgt_q, tgt_d;
    logic           pend_q, pend_d;
    logic [W-1:0]   tgt_aligned;

`ifdef IFU_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
`endif

    assign tgt_aligned = redirect_target & {{(W-2){1'b1}}, 2'b00};

    // NOTE: every variable gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        tgt_d   = tgt_q;
        pend_d  = pend_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d   = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (redirect) pc_d = tgt_aligned;
                state_d = FETCH;
`ifdef IFU_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            FETCH: begin
                if (imem_ack) begin
`ifdef IFU_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    // A redirect seen during or at the end of this fetch makes the word stale.
                    if (redirect) begin
                        pc_d   = tgt_aligned;
                        pend_d = 1'b0;
                    end else if (pend_q) begin
                        pc_d   = tgt_q;
                        pend_d = 1'b0;
                    end else begin
                        instr_d = imem_rdata;
                        state_d = VALID;
                    end
                end else begin
                    if (redirect) begin
                        tgt_d  = tgt_aligned;
                        pend_d = 1'b1;
                    end
`ifdef IFU_TIMEOUT_EN
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == CNT_W'(TIMEOUT_CYC)) state_d = ERR;
`endif
                end
            end
            VALID: begin
                if (redirect) begin
                    pc_d    = tgt_aligned;
                    state_d = FETCH;
                end else if (instr_ready) begin
                    pc_d    = pc_q + W'(4);
                    state_d = FETCH;
                end
`ifdef IFU_TIMEOUT_EN
                if (redirect || instr_ready) cnt_d = '0;
`endif
            end
`ifdef IFU_TIMEOUT_EN
            ERR: state_d = ERR;
`endif
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            tgt_q   <= '0;
            pend_q  <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            tgt_q   <= tgt_d;
            pend_q  <= pend_d;
`ifdef IFU_TIMEOUT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign imem_req    = (state_q == FETCH);
    assign imem_addr   = pc_q;
    assign instr       = instr_q;
    assign instr_valid = (state_q == VALID);
    assign PC_now      = pc_q;
    assign PC_plus4    = pc_q + W'(4);

`ifdef IFU_TIMEOUT_EN
    assign fetch_err = (state_q == ERR);
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: tb/tb_ifu.sv
// Self-checking bench for ifu: cycle table, reset/timeout sequences, randomized run vs. fetch-stream model.
`timescale 1ns/1ps

module tb_ifu;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] PC_now;
    logic [31:0] PC_plus4;
    logic        redirect = 1'b0;
    logic [31:0] redirect_target = '0;
    logic        fetch_err;

    int n_checks = 0;
    int n_fail   = 0;

    ifu #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .PC_now(PC_now), .PC_plus4(PC_plus4),
        .redirect(redirect), .redirect_target(redirect_target),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    task automatic drive(input logic ack, input logic [31:0] rdata, input logic rdy,
                         input logic redir, input logic [31:0] tgt);
        imem_ack        = ack;
        imem_rdata      = rdata;
        instr_ready     = rdy;
        redirect        = redir;
        redirect_target = tgt;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    typedef struct {
        logic        ack;
        logic        ready;
        logic        redir;
        logic [31:0] target;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    function automatic vec_t row(input logic er, input logic [31:0] ea, input logic ev,
                                 input logic [31:0] ep, input logic ack, input logic [31:0] rd,
                                 input logic rdy, input logic redir, input logic [31:0] tgt);
        vec_t v;
        v.exp_req = er; v.exp_addr = ea; v.exp_valid = ev; v.exp_pc = ep;
        v.ack = ack; v.rdata = rd; v.ready = rdy; v.redir = redir; v.target = tgt;
        return v;
    endfunction

    vec_t tbl[$];

    logic [31:0] exp_pc;
    logic        prev_req, prev_ack, prev_valid;
    logic [31:0] prev_addr;
    int          wait_cnt;
    logic        a, rdy, rd;
    logic [31:0] tgt;

    initial begin
        // Observed state, then inputs applied for the following rising edge.
        tbl.push_back(row(0, 32'h0,        0, 32'h0,        0, 32'h0,                 0, 0, 32'h0));
        tbl.push_back(row(1, 32'h0,        0, 32'h0,        1, mem_word(32'h0),       1, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'h0,        1, 32'h0,                 1, 0, 32'h0));
        tbl.push_back(row(1, 32'h4,        0, 32'h0,        1, mem_word(32'h4),       1, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'h4,        1, 32'h0,                 1, 0, 32'h0));
        tbl.push_back(row(1, 32'h8,        0, 32'h0,        1, mem_word(32'h8),       0, 0, 32'h0));
        for (int k = 0; k < 5; k++)
            tbl.push_back(row(0, 32'h0,    1, 32'h8,        0, 32'h0,                 0, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'h8,        0, 32'h0,                 1, 0, 32'h0));
        tbl.push_back(row(1, 32'hC,        0, 32'h0,        0, 32'h0,                 0, 1, 32'h0000_0103));
        tbl.push_back(row(1, 32'hC,        0, 32'h0,        0, 32'h0,                 0, 0, 32'h0));
        tbl.push_back(row(1, 32'hC,        0, 32'h0,        0, 32'h0,                 0, 0, 32'h0));
        tbl.push_back(row(1, 32'hC,        0, 32'h0,        1, 32'hDEAD_BEEF,         0, 0, 32'h0));
        tbl.push_back(row(1, 32'h100,      0, 32'h0,        1, mem_word(32'h100),     0, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'h100,      0, 32'h0,                 0, 1, 32'hFFFF_FFFC));
        tbl.push_back(row(1, 32'hFFFF_FFFC,0, 32'h0,        1, mem_word(32'hFFFF_FFFC),0, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'hFFFF_FFFC,0, 32'h0,                 1, 0, 32'h0));
        tbl.push_back(row(1, 32'h0,        0, 32'h0,        1, 32'hBAD0_BAD0,         0, 1, 32'h0000_0040));
        tbl.push_back(row(1, 32'h40,       0, 32'h0,        1, mem_word(32'h40),      0, 0, 32'h0));
        tbl.push_back(row(0, 32'h0,        1, 32'h40,       0, 32'h0,                 1, 1, 32'h0000_0205));
        tbl.push_back(row(1, 32'h204,      0, 32'h0,        0, 32'h0,                 0, 0, 32'h0));

        // Reset values while rst is held.
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check("rst_req",   32'(imem_req),    32'h0);
        check("rst_addr",  imem_addr,        32'h0);
        check("rst_valid", 32'(instr_valid), 32'h0);
        check("rst_instr", instr,            32'h0);
        check("rst_err",   32'(fetch_err),   32'h0);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) begin
            check($sformatf("row%0d_req", i),   32'(imem_req),    32'(tbl[i].exp_req));
            if (tbl[i].exp_req)
                check($sformatf("row%0d_addr", i), imem_addr, tbl[i].exp_addr);
            check($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].exp_valid) begin
                check($sformatf("row%0d_pc", i),    PC_now,   tbl[i].exp_pc);
                check($sformatf("row%0d_instr", i), instr,    mem_word(tbl[i].exp_pc));
                check($sformatf("row%0d_plus4", i), PC_plus4, tbl[i].exp_pc + 32'd4);
            end
            drive(tbl[i].ack, tbl[i].rdata, tbl[i].ready, tbl[i].redir, tbl[i].target);
            @(negedge clk);
        end

        // Redirect in IDLE, then reset during FETCH with a simultaneous ack.
        do_reset();
        check("idle_req", 32'(imem_req), 32'h0);
        drive(1'b0, '0, 1'b0, 1'b1, 32'h0000_0083);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check("idle_redir_req",  32'(imem_req), 32'h1);
        check("idle_redir_addr", imem_addr,     32'h0000_0080);
        rst = 1'b1;
        drive(1'b1, mem_word(32'h80), 1'b1, 1'b0, '0);
        #1;
        check("async_rst_req",  32'(imem_req), 32'h0);
        check("async_rst_addr", imem_addr,     32'h0);
        @(negedge clk);
        check("rst_ack_valid", 32'(instr_valid), 32'h0);
        check("rst_ack_instr", instr,            32'h0);
        rst = 1'b0;
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check("post_rst_idle", 32'(imem_req), 32'h0);
        @(negedge clk);
        check("post_rst_req",  32'(imem_req), 32'h1);
        check("post_rst_addr", imem_addr,     32'h0);
        drive(1'b1, mem_word(32'h0), 1'b0, 1'b0, '0);
        @(negedge clk);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        check("post_rst_valid", 32'(instr_valid), 32'h1);
        check("post_rst_pc",    PC_now,           32'h0);

        // Ack withheld.
        do_reset();
        @(negedge clk);
`ifdef IFU_TIMEOUT_EN
        for (int k = 0; k < 16; k++) begin
            check($sformatf("to_wait%0d_req", k), 32'(imem_req),  32'h1);
            check($sformatf("to_wait%0d_err", k), 32'(fetch_err), 32'h0);
            @(negedge clk);
        end
        for (int k = 0; k < 4; k++) begin
            check($sformatf("to_err%0d_err", k),   32'(fetch_err),   32'h1);
            check($sformatf("to_err%0d_req", k),   32'(imem_req),    32'h0);
            check($sformatf("to_err%0d_valid", k), 32'(instr_valid), 32'h0);
            drive(1'b1, mem_word(32'h0), 1'b1, 1'b1, 32'h0000_0200);
            @(negedge clk);
        end
        do_reset();
        check("to_rst_err", 32'(fetch_err), 32'h0);
        @(negedge clk);
        check("to_restart_req",  32'(imem_req), 32'h1);
        check("to_restart_addr", imem_addr,     32'h0);
`else
        for (int k = 0; k < 24; k++) begin
            check($sformatf("nack%0d_req", k),  32'(imem_req),  32'h1);
            check($sformatf("nack%0d_addr", k), imem_addr,      32'h0);
            check($sformatf("nack%0d_err", k),  32'(fetch_err), 32'h0);
            @(negedge clk);
        end
`endif

        // Randomized run against the expected fetch stream.
        do_reset();
        exp_pc     = 32'h0;
        prev_req   = 1'b0;
        prev_ack   = 1'b0;
        prev_valid = 1'b0;
        prev_addr  = '0;
        wait_cnt   = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (instr_valid) begin
                check("rnd_pc",    PC_now,        exp_pc);
                check("rnd_instr", instr,         mem_word(PC_now));
                check("rnd_plus4", PC_plus4,      PC_now + 32'd4);
                check("rnd_noreq", 32'(imem_req), 32'h0);
                if (!prev_valid) check("rnd_valid_after_ack", 32'(prev_req && prev_ack), 32'h1);
            end
            if (prev_req && !prev_ack) begin
                check("rnd_req_hold",  32'(imem_req), 32'h1);
                check("rnd_addr_hold", imem_addr,     prev_addr);
            end else if (imem_req) begin
                check("rnd_new_addr", imem_addr, exp_pc);
            end

            a   = imem_req && (($urandom_range(0, 2) == 0) || wait_cnt >= 4);
            rdy = instr_valid && ($urandom_range(0, 1) == 1);
            rd  = (imem_req || instr_valid) && ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            drive(a, a ? mem_word(imem_addr) : $urandom, rdy, rd, tgt);

            if (rd)                      exp_pc = tgt & 32'hFFFF_FFFC;
            else if (instr_valid && rdy) exp_pc = exp_pc + 32'd4;
            wait_cnt   = (imem_req && !a) ? wait_cnt + 1 : 0;
            prev_req   = imem_req;
            prev_ack   = a;
            prev_valid = instr_valid;
            prev_addr  = imem_addr;
            @(negedge clk);
        end
        check("rnd_err_clear", 32'(fetch_err), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
